// File: rtl/bus_responder.sv
// CPU bus responder: byte-wide RAM plus memory-mapped UART TX/RX FIFOs and a cycle counter.
// Define BUS_RESPONDER_CYCLE_COUNTER_EN to build the cycle counter and its snapshot register.
module bus_responder #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH       = 8,
  parameter int unsigned RX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] bus_a,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam logic [TxAw:0] TxCntFull   = (TxAw + 1)'(TX_DEPTH);
  localparam logic [TxAw:0] TxCntAlmost = (TxAw + 1)'(TX_DEPTH - 1);
  localparam logic [RxAw:0] RxCntFull   = (RxAw + 1)'(RX_DEPTH);

  // Address decode and qualified CPU strobes
  logic        is_io, sel_data, sel_stop, cpu_rd, cpu_wr;
  logic [15:0] io_off;
  logic        unused_bus_a;

  assign is_io        = bus_a[17:16] == 2'b11;
  assign io_off       = bus_a[15:0];
  assign sel_data     = is_io && (io_off == 16'h0000);
  assign sel_stop     = is_io && (io_off == 16'h0004);
  assign cpu_rd       = rdy_in && !bus_wr;
  assign cpu_wr       = rdy_in && bus_wr;
  assign unused_bus_a = ^bus_a[31:18];

  // RAM: no reset, contents survive rst_in
  logic [7:0]                ram [2**RAM_ADDR_WIDTH];
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]                ram_rdata_q;

  assign ram_addr = bus_a[RAM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (cpu_wr && !is_io) ram[ram_addr] <= bus_wdata;
    if (cpu_rd) ram_rdata_q <= ram[ram_addr];
  end

  // TX FIFO
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxAw-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TxAw:0]   tx_cnt_q;
  logic            tx_full, tx_push_req, tx_push, tx_pop;
  logic [7:0]      tx_push_data;

  assign tx_full        = tx_cnt_q == TxCntFull;
  assign tx_valid       = tx_cnt_q != '0;
  assign tx_data        = tx_mem[tx_rd_ptr_q];
  assign io_buffer_full = tx_cnt_q >= TxCntAlmost;
  assign tx_pop         = tx_valid && tx_ready;
  // The stop marker bypasses the zero filter so the sink sees an explicit 0x00
  assign tx_push_req    = cpu_wr && (sel_stop || (sel_data && bus_wdata != 8'h00));
  assign tx_push_data   = sel_stop ? 8'h00 : bus_wdata;
  // A same-cycle pop frees a slot in a full FIFO
  assign tx_push        = tx_push_req && (!tx_full || tx_pop);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_push_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_cnt_q     <= '0;
      tx_overflow  <= 1'b0;
      program_done <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + 1'b1;
      if (tx_pop) tx_rd_ptr_q <= tx_rd_ptr_q + 1'b1;
      if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - 1'b1;
      if (tx_push_req && !tx_push) tx_overflow <= 1'b1;
      if (cpu_wr && sel_stop) program_done <= 1'b1;
    end
  end

  // RX FIFO
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RxAw-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RxAw:0]   rx_cnt_q;
  logic            rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full  = rx_cnt_q == RxCntFull;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_push  = rx_valid && !rx_full;
  // Emptiness is from registered state, so a same-cycle push is not readable
  assign rx_pop   = cpu_rd && sel_data && !rx_empty;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + 1'b1;
      if (rx_pop) rx_rd_ptr_q <= rx_rd_ptr_q + 1'b1;
      if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q, cycle_snap_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle_cnt_q  <= '0;
      cycle_snap_q <= '0;
    end else if (rdy_in) begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (!bus_wr && sel_stop) cycle_snap_q <= cycle_cnt_q;
    end
  end
`endif

  // I/O read mux
  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    if (is_io) begin
      case (io_off)
        16'h0000: io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
        // Byte 0 comes live from the counter, the rest from the snapshot taken with it
        16'h0004: io_rdata = cycle_cnt_q[7:0];
        16'h0005: io_rdata = cycle_snap_q[15:8];
        16'h0006: io_rdata = cycle_snap_q[23:16];
        16'h0007: io_rdata = cycle_snap_q[31:24];
`endif
        default:  io_rdata = 8'h00;
      endcase
    end
  end

  // Read-return registers; reset selects the zeroed I/O path
  logic       rd_io_q;
  logic [7:0] io_rdata_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_io_q    <= 1'b1;
      io_rdata_q <= 8'h00;
    end else if (cpu_rd) begin
      rd_io_q    <= is_io;
      io_rdata_q <= io_rdata;
    end
  end

  assign bus_rdata = rd_io_q ? io_rdata_q : ram_rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed steps with randomized data,
// checked against queue/array reference models kept here.
module tb_bus_responder;

  localparam int unsigned RamAw   = 17;
  localparam int unsigned TxDepth = 8;
  localparam int unsigned RxDepth = 8;
`ifdef BUS_RESPONDER_CYCLE_COUNTER_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [31:0] bus_a = '0;
  logic [7:0]  bus_wdata = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        program_done;
  logic        tx_overflow;

  bus_responder #(
    .RAM_ADDR_WIDTH(RamAw),
    .TX_DEPTH      (TxDepth),
    .RX_DEPTH      (RxDepth)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .bus_a         (bus_a),
    .bus_wdata     (bus_wdata),
    .bus_wr        (bus_wr),
    .bus_rdata     (bus_rdata),
    .io_buffer_full(io_buffer_full),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .program_done  (program_done),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int          errs = 0;
  int          checks = 0;
  int unsigned model_cnt = 0;
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [7:0]  ram_m [int];
  bit          ovf_m = 1'b0;
  bit          done_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every rising edge goes through here so the counter model sees all of them
  task automatic tick();
    @(posedge clk_in);
    if (rdy_in && !rst_in) model_cnt++;
  endtask

  task automatic step(input logic [31:0] a, input bit wr, input logic [7:0] d,
                      input bit rv, input logic [7:0] rd);
    @(negedge clk_in);
    bus_a = a; bus_wr = wr; bus_wdata = d; rx_valid = rv; rx_data = rd;
    tick();
    #1;
  endtask

  task automatic bus_op(input logic [31:0] a, input bit wr, input logic [7:0] d);
    step(a, wr, d, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    bus_a = '0; bus_wr = 1'b0; bus_wdata = '0; rx_valid = 1'b0;
    repeat (n) tick();
    #1;
  endtask

  task automatic ram_write(input logic [31:0] a, input logic [7:0] d);
    bus_op(a, 1'b1, d);
    ram_m[int'(a)] = d;
  endtask

  // CPU-side TX write while the sink is stalled
  task automatic tx_write(input logic [31:0] a, input logic [7:0] d);
    bus_op(a, 1'b1, d);
    if (a == 32'h30004) begin
      done_m = 1'b1;
      if (txq.size() < TxDepth) txq.push_back(8'h00);
      else ovf_m = 1'b1;
    end else if (a == 32'h30000 && d != 8'h00) begin
      if (txq.size() < TxDepth) txq.push_back(d);
      else ovf_m = 1'b1;
    end
    chk("tx_almost_full", io_buffer_full, 32'(txq.size() >= TxDepth - 1));
    chk("tx_overflow", tx_overflow, 32'(ovf_m));
    chk("tx_valid", tx_valid, 32'(txq.size() != 0));
  endtask

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    while (txq.size() != 0) begin
      chk({tag, "_valid"}, tx_valid, 1);
      chk({tag, "_data"}, tx_data, txq.pop_front());
      idle(1);
    end
    chk({tag, "_empty"}, tx_valid, 0);
    tx_ready = 1'b0;
  endtask

  task automatic check_counter(input string tag);
    logic [31:0] snap;
    snap = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (i == 0) snap = model_cnt;
      bus_a = 32'h30004 + i; bus_wr = 1'b0; rx_valid = 1'b0;
      tick();
      #1;
      chk(tag, bus_rdata, CntEn ? 32'(snap[8*i +: 8]) : 32'h0);
    end
  endtask

  task automatic apply_reset();
    bus_a = '0; bus_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    txq.delete(); rxq.delete();
    ovf_m = 1'b0; done_m = 1'b0; model_cnt = 0;
    chk("rst_rdata", bus_rdata, 8'h00);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_almost_full", io_buffer_full, 0);
    chk("rst_done", program_done, 0);
    chk("rst_overflow", tx_overflow, 0);
    repeat (2) tick();
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
    int unsigned addrs [$];

    apply_reset();

    // RAM: write then immediate read-back, then randomized pairs
    ram_write(32'h10, 8'hA5);
    bus_op(32'h10, 1'b0, 8'h00);
    chk("ram_a5", bus_rdata, 8'hA5);
    ram_write(32'h1FFFF, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(32'h100, 32'h1FFFE);
      d = 8'($urandom);
      ram_write(a, d);
      addrs.push_back(a);
    end
    foreach (addrs[i]) begin
      bus_op(addrs[i], 1'b0, 8'h00);
      chk("ram_rand", bus_rdata, ram_m[int'(addrs[i])]);
    end
    bus_op(32'h30010, 1'b1, 8'h77);
    bus_op(32'h30010, 1'b0, 8'h00);
    chk("io_unmapped", bus_rdata, 8'h00);

    // Frozen CPU side: no RAM write, no TX push, no RX pop, rdata holds; RX stream still runs
    bus_op(32'h1FFFF, 1'b0, 8'h00);
    chk("frz_pre", bus_rdata, 8'h5A);
    check_counter("cnt_pre_freeze");
    bus_op(32'h1FFFF, 1'b0, 8'h00);
    rdy_in = 1'b0;
    step(32'h10, 1'b1, 8'hEE, 1'b1, 8'h77);
    chk("frz_hold_wr", bus_rdata, 8'h5A);
    bus_op(32'h10, 1'b0, 8'h00);
    chk("frz_hold_rd", bus_rdata, 8'h5A);
    bus_op(32'h30000, 1'b1, 8'h42);
    chk("frz_no_tx", tx_valid, 0);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("frz_no_pop", bus_rdata, 8'h5A);
    idle(6);
    rdy_in = 1'b1;
    bus_op(32'h10, 1'b0, 8'h00);
    chk("frz_no_ramwr", bus_rdata, ram_m[32'h10]);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("frz_rx_push", bus_rdata, 8'h77);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("frz_rx_empty", bus_rdata, 8'h00);
    check_counter("cnt_post_freeze");

    // Full TX FIFO with simultaneous push and pop
    for (int i = 0; i < TxDepth; i++) tx_write(32'h30000, 8'($urandom_range(1, 255)));
    chk("tx_head", tx_data, txq[0]);
    d = 8'($urandom_range(1, 255));
    tx_ready = 1'b1;
    bus_op(32'h30000, 1'b1, d);
    void'(txq.pop_front());
    txq.push_back(d);
    chk("pushpop_ovf", tx_overflow, 0);
    chk("pushpop_full", io_buffer_full, 1);
    drain("pushpop_drain");

    // Fill, almost-full, accept 8th, drop 9th, zero filter
    for (int i = 0; i < 9; i++) tx_write(32'h30000, 8'h41);
    tx_write(32'h30000, 8'h00);
    chk("tx_zero_ignored", 32'(txq.size()), TxDepth);
    drain("fill_drain");

    // Stop marker with the sink ready
    tx_ready = 1'b1;
    bus_op(32'h30004, 1'b1, 8'h55);
    txq.push_back(8'h00);
    done_m = 1'b1;
    chk("stop_done", program_done, 32'(done_m));
    chk("stop_valid", tx_valid, 1);
    chk("stop_data", tx_data, 8'h00);
    chk("stop_ovf_kept", tx_overflow, 32'(ovf_m));
    drain("stop_drain");

    // RX ordering and empty read
    step(32'h0, 1'b0, 8'h00, 1'b1, 8'h31);
    step(32'h0, 1'b0, 8'h00, 1'b1, 8'h32);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("rx_31", bus_rdata, 8'h31);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("rx_32", bus_rdata, 8'h32);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("rx_empty", bus_rdata, 8'h00);

    // Push into empty RX not visible to same-cycle read
    step(32'h30000, 1'b0, 8'h00, 1'b1, 8'h99);
    chk("rx_same_cycle", bus_rdata, 8'h00);
    bus_op(32'h30000, 1'b0, 8'h00);
    chk("rx_next_cycle", bus_rdata, 8'h99);

    // Overfill RX with random bytes, then read everything back
    for (int i = 0; i < RxDepth + 3; i++) begin
      d = 8'($urandom_range(1, 255));
      step(32'h0, 1'b0, 8'h00, 1'b1, d);
      if (rxq.size() < RxDepth) rxq.push_back(d);
    end
    for (int i = 0; i < RxDepth + 1; i++) begin
      exp = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
      bus_op(32'h30000, 1'b0, 8'h00);
      chk("rx_rand", bus_rdata, exp);
    end
    chk("done_sticky", program_done, 1);
    chk("ovf_sticky", tx_overflow, 1);

    // Reset in the middle of a queued TX burst; RAM survives
    for (int i = 0; i < 5; i++) tx_write(32'h30000, 8'($urandom_range(1, 255)));
    chk("mid_tx_valid", tx_valid, 1);
    apply_reset();
    idle(1);
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_almost", io_buffer_full, 0);
    bus_op(32'h1FFFF, 1'b0, 8'h00);
    chk("ram_survives_rst", bus_rdata, 8'h5A);

    // Counter after ~100 free-running cycles
    idle(100);
    check_counter("cnt_100");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
